// File: rtl/psum_pkg.sv
// Shared types, default widths and the shift/round/saturate helper for the partial-sum path.
// Build option: PSUM_ROUND_EN selects round-half-up before the shift (default: truncate toward -inf).
package psum_pkg;

    localparam int DEF_IN_W  = 32;
    localparam int DEF_ACC_W = 40;
    localparam int DEF_OUT_W = 16;
    localparam int SAT_W     = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic signed [SAT_W-1:0] val;
        logic                    sat;
    } sat_res_t;

    // acc arrives sign-extended to SAT_W; val comes back clamped to the out_w signed range.
    function automatic sat_res_t sat_shift(input logic signed [SAT_W-1:0] acc,
                                           input int shift, input int out_w);
        sat_res_t r;
        logic signed [SAT_W-1:0] full, hi, lo;
`ifdef PSUM_ROUND_EN
        if (shift > 0)
            full = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
        else
            full = acc;
`else
        full = acc >>> shift;
`endif
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        r.sat = 1'b1;
        if (full > hi)
            r.val = hi;
        else if (full < lo)
            r.val = lo;
        else begin
            r.val = full;
            r.sat = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/psum_sat_round.sv
// Combinational rescale + saturate of a wide signed accumulator to OUT_W bits.
// Rounding behaviour follows PSUM_ROUND_EN through psum_pkg::sat_shift.
module psum_sat_round
    import psum_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int SHIFT = 8
) (
    input  logic signed [ACC_W-1:0] acc_in,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_sat
);

    sat_res_t res;

    assign res      = sat_shift(SAT_W'(acc_in), SHIFT, OUT_W);
    assign out_data = res.val[OUT_W-1:0];
    assign out_sat  = res.sat;

endmodule

// File: rtl/psum_accumulator_16bit.sv
// Accumulates NUM_CHUNKS adder-tree partial sums, rescales/saturates, and hands the
// 16-bit result downstream with valid/ready. PSUM_ROUND_EN enables round-half-up.
module psum_accumulator_16bit
    import psum_pkg::*;
#(
    parameter int IN_W       = DEF_IN_W,
    parameter int ACC_W      = DEF_ACC_W,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int NUM_CHUNKS = 4,
    parameter int SHIFT      = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic signed [IN_W-1:0]  in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sat,
    output logic                    busy
);

    localparam int CNT_W = $clog2(NUM_CHUNKS + 1);

    state_t                  state, state_nxt;
    logic signed [ACC_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0]        cnt;
    logic                    in_acc, out_acc, last;
    logic signed [OUT_W-1:0] res_data;
    logic                    res_sat;

    assign in_acc  = in_valid && in_ready;
    assign out_acc = out_valid && out_ready;
    assign last    = (cnt == CNT_W'(NUM_CHUNKS - 1));
    // acc is zero whenever a new result starts, so one adder covers IDLE and ACCUM.
    assign acc_nxt = acc + ACC_W'(in_data);

    psum_sat_round #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_sat (
        .acc_in   (acc_nxt),
        .out_data (res_data),
        .out_sat  (res_sat)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_acc) state_nxt = last ? EMIT : ACCUM;
                ACCUM:   if (in_acc && last) state_nxt = EMIT;
                EMIT:    if (out_acc) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = (state != EMIT);
        busy     = (state != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
        end else if (clear) begin
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else if (in_acc) begin
            if (last) begin
                acc       <= '0;
                cnt       <= '0;
                out_data  <= res_data;
                out_sat   <= res_sat;
                out_valid <= 1'b1;
            end else begin
                acc <= acc_nxt;
                cnt <= cnt + CNT_W'(1);
            end
        end else if (out_acc) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/psum_accumulator_16bit.md
Name: psum_accumulator_16bit

Overview:
- Downstream stage of the 16-bit adder trees: consumes the 32-bit tree sum, one partial sum per beat.
- Accumulates NUM_CHUNKS partial sums into one dot-product result, then rescales and saturates it to signed 16-bit.
- Presents the 16-bit result with a valid/ready handshake to the tanh/sigmoid activation stage.

Parameters:
- IN_W, 32, width of incoming signed partial sum (adder tree sum_out)
- ACC_W, 40, internal signed accumulator width; must be >= IN_W + clog2(NUM_CHUNKS)
- OUT_W, 16, width of signed saturated output
- NUM_CHUNKS, 4, partial sums per result; legal range 1..256
- SHIFT, 8, arithmetic right shift applied before saturation (fixed-point realignment)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous abort: discards the partial accumulation and returns to IDLE
- in_data  in  IN_W  signed partial sum from adder tree
- in_valid  in  1  in_data valid this cycle
- in_ready  out  1  block accepts in_data this cycle
- out_data  out  OUT_W  signed saturated result
- out_valid  out  1  out_data valid; held until accepted
- out_ready  in  1  downstream accepts out_data
- out_sat  out  1  qualified by out_valid; 1 if saturation clipped the result
- busy  out  1  high in ACCUM or EMIT

Behaviour:
- Reset (async, active-high): state=IDLE, acc=0, cnt=0, out_data=0, out_valid=0, out_sat=0. in_ready=1 after reset deasserts. Reset mid-accumulation or mid-EMIT discards all data.
- An input beat is accepted when in_valid && in_ready. An output beat is taken when out_valid && out_ready.
- in_ready = 1 in IDLE and ACCUM; 0 in EMIT.
- IDLE:
  - On accept: acc <= sext(in_data), cnt <= 1.
  - If NUM_CHUNKS==1, the beat completes the result immediately (see Completion).
  - Otherwise go to ACCUM.
- ACCUM:
  - On accept: acc <= acc + sext(in_data), cnt <= cnt+1.
  - When the accepted beat is number NUM_CHUNKS, it completes the result.
  - Idle input cycles are allowed; there is no timeout.
- Completion (same edge as the final accept):
  - full = acc_next >>> SHIFT (arithmetic shift).
  - Clamp full to [-2^(OUT_W-1), 2^(OUT_W-1)-1], i.e. [-32768, 32767].
  - out_data <= clamped value; out_sat <= (clamped != full); out_valid <= 1.
  - State goes to EMIT; acc and cnt reset to 0.
- Latency: the result is valid 1 cycle after the final input accept.
- EMIT:
  - out_data and out_sat are held stable while out_valid && !out_ready.
  - On output accept: out_valid <= 0, next state IDLE.
  - in_ready is low throughout EMIT, so there is no overlap with the next result; throughput is NUM_CHUNKS+1 cycles per result with out_ready tied high.
- clear:
  - Takes priority over a simultaneous input accept; the beat presented in that cycle is dropped.
  - From IDLE or ACCUM: acc=0, cnt=0, state IDLE.
  - From EMIT: out_valid <= 0 and the pending result is discarded, even if out_ready is high in the same cycle.
- Accumulator width: ACC_W is sized so the sum cannot wrap. No internal overflow detection is required.
- Counter: cnt width = clog2(NUM_CHUNKS+1); never wraps.

Optional Feature:
- Macro: PSUM_ROUND_EN.
- Defined: round half up before shifting, full = (acc_next + 2^(SHIFT-1)) >>> SHIFT, applied before saturation. When SHIFT==0, no rounding term is added.
- Undefined: pure truncation toward -inf (plain arithmetic shift).
- Ports and latency are identical in both builds.

Decomposition:
- Shared package psum_pkg holds:
  - state enum {IDLE, ACCUM, EMIT}
  - default width constants (IN_W, ACC_W, OUT_W)
  - function sat_shift(acc, shift) returning the clamped value and sat flag
- One sub-module, psum_sat_round: purely combinational shift/round/saturate, parameterised by ACC_W, OUT_W and SHIFT. It is reusable ahead of other activation stages.
- The FSM, counter and accumulator stay in the top module.

Test Plan:
- Basic: NUM_CHUNKS=4, SHIFT=8, out_ready=1; inputs 256, 512, 768, 1024 on consecutive cycles -> out_data=10, out_sat=0, out_valid exactly one cycle after the 4th accept.
- Saturation: inputs 0x00400000 ×4 -> out_data=32767, out_sat=1. Inputs -0x00400000 ×4 -> out_data=-32768, out_sat=1.
- Backpressure: hold out_ready=0 for 5 cycles after the result -> out_data stable, in_ready=0 throughout; a 5th in_valid beat is not accepted until the cycle after the output handshake.
- Clear: assert clear with in_valid after 2 beats of 100 -> that beat is dropped. Then beats 256 ×4 -> out_data=4 (no residue from the earlier beats).
- Rounding: inputs 128, 0, 0, 0 with SHIFT=8 -> out_data=1 with PSUM_ROUND_EN defined, 0 without. Inputs -129, 0, 0, 0 -> -1 with it defined, -1 without.
- Reset mid-ACCUM: async reset after 3 beats -> out_valid=0 immediately, in_ready=1 after release; the next 4 beats of 256 give out_data=4.
